// File: rtl/wptr_full_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wptr_full_ctrl_pkg
//  Description : Shared constants and width helpers for the async-FIFO
//                write-side pointer/flag controller. Holds the default address
//                width, the DEPTH derivation and the Gray/binary pointer width.
//  Revision    : 1.0  initial release
// ============================================================================
package wptr_full_ctrl_pkg;

    // Default FIFO address width (DEPTH = 8).
    localparam int c_DEFAULT_ADDR_WIDTH = 3;

    // Legal address width range for the controller.
    localparam int c_MIN_ADDR_WIDTH = 2;
    localparam int c_MAX_ADDR_WIDTH = 12;

    // Number of FIFO entries for a given address width.
    function automatic int calc_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Pointer width: one extra MSB distinguishes full from empty when the
    // low address bits coincide. Same width for Gray and binary forms.
    function automatic int calc_ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Default almost-full threshold: two entries short of full.
    function automatic int calc_afull_default(input int addr_width);
        return calc_depth(addr_width) - 2;
    endfunction

endpackage : wptr_full_ctrl_pkg
`default_nettype wire

// File: rtl/bin_to_gray_converter.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_gray_converter
//  Description : Purely combinational binary-to-Gray conversion.
//                Ports: i_bin  [WIDTH-1:0] binary input
//                       o_gray [WIDTH-1:0] reflected Gray code output
//  Revision    : 1.0  initial release
// ============================================================================
module bin_to_gray_converter #(
    parameter int WIDTH = 4
) (
    input  wire logic [WIDTH-1:0] i_bin,
    output logic      [WIDTH-1:0] o_gray
);

    assign o_gray = i_bin ^ (i_bin >> 1);

endmodule : bin_to_gray_converter
`default_nettype wire

// File: rtl/gray_to_bin_converter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_to_bin_converter
//  Description : Purely combinational Gray-to-binary conversion. Each binary
//                bit is the XOR of all Gray bits at and above its position.
//                Ports: i_gray [WIDTH-1:0] reflected Gray code input
//                       o_bin  [WIDTH-1:0] binary output
//  Revision    : 1.0  initial release
// ============================================================================
module gray_to_bin_converter #(
    parameter int WIDTH = 4
) (
    input  wire logic [WIDTH-1:0] i_gray,
    output logic      [WIDTH-1:0] o_bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[WIDTH-1:i];
    end

endmodule : gray_to_bin_converter
`default_nettype wire

// File: rtl/wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wptr_full_ctrl
//  Description : Write-domain pointer and flag controller for an asynchronous
//                FIFO. Keeps the binary write pointer, produces the registered
//                RAM write address and Gray write pointer, and derives full,
//                almost-full, occupancy and a sticky overflow flag against the
//                read pointer already synchronised into wclk.
//
//  Ports       : wclk          write-domain clock (rising edge)
//                wrst          synchronous active-high reset
//                winc          write request
//                sync_rptr     Gray read pointer, synchronised to wclk
//                afull_thresh  almost-full level, 1..DEPTH (0 = use AFULL_RESET)
//                clr_ovf       clears the sticky overflow flag
//                waddr         registered RAM write address
//                wptr          registered Gray write pointer
//                wfull         registered full flag
//                wafull        registered almost-full flag
//                wlevel        registered write-side occupancy, 0..DEPTH
//                wovf          sticky overflow flag
//  Revision    : 1.0  initial release
// ============================================================================
module wptr_full_ctrl
    import wptr_full_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = c_DEFAULT_ADDR_WIDTH,
    parameter int AFULL_RESET = calc_afull_default(ADDR_WIDTH)
) (
    input  wire logic                  wclk,
    input  wire logic                  wrst,
    input  wire logic                  winc,
    input  wire logic [ADDR_WIDTH:0]   sync_rptr,
    input  wire logic [ADDR_WIDTH:0]   afull_thresh,
    input  wire logic                  clr_ovf,
    output logic      [ADDR_WIDTH-1:0] waddr,
    output logic      [ADDR_WIDTH:0]   wptr,
    output logic                       wfull,
    output logic                       wafull,
    output logic      [ADDR_WIDTH:0]   wlevel,
    output logic                       wovf
);

    localparam int c_PTR_W = calc_ptr_width(ADDR_WIDTH);

    localparam logic [c_PTR_W-1:0] c_AFULL_RESET = c_PTR_W'(AFULL_RESET);
    localparam logic [c_PTR_W-1:0] c_PTR_ZERO    = '0;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [c_PTR_W-1:0]    r_wbin;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [c_PTR_W-1:0]    r_wptr;
    logic                  r_wfull;
    logic                  r_wafull;
    logic [c_PTR_W-1:0]    r_wlevel;
    logic                  r_wovf;

    // ------------------------------------------------------------------
    // Next-state datapath
    // ------------------------------------------------------------------
    logic                  w_accept;
    logic                  w_overflow;
    logic [c_PTR_W-1:0]    w_wbin_next;
    logic [c_PTR_W-1:0]    w_wgray_next;
    logic [c_PTR_W-1:0]    w_rbin;
    logic [c_PTR_W-1:0]    w_rptr_full_cmp;
    logic [c_PTR_W-1:0]    w_wlevel_next;
    logic [c_PTR_W-1:0]    w_thresh;
    logic                  w_wfull_next;
    logic                  w_wafull_next;
    logic                  w_wovf_next;

    // Acceptance looks only at the registered full flag, so a slot freed by
    // sync_rptr in this very cycle cannot admit the current write.
    assign w_accept   = winc & ~r_wfull;
    assign w_overflow = winc &  r_wfull;

    assign w_wbin_next = r_wbin + {c_PTR_ZERO[c_PTR_W-1:1], w_accept};

    bin_to_gray_converter #(
        .WIDTH (c_PTR_W)
    ) u_bin_to_gray (
        .i_bin  (w_wbin_next),
        .o_gray (w_wgray_next)
    );

    gray_to_bin_converter #(
        .WIDTH (c_PTR_W)
    ) u_gray_to_bin (
        .i_gray (sync_rptr),
        .o_bin  (w_rbin)
    );

    // In Gray code, "write pointer exactly one lap ahead of read pointer"
    // means the two MSBs differ and all lower bits match.
    assign w_rptr_full_cmp = {~sync_rptr[ADDR_WIDTH:ADDR_WIDTH-1],
                               sync_rptr[ADDR_WIDTH-2:0]};

    // An unprogrammed threshold register reads as zero, which is outside the
    // legal 1..DEPTH range; fall back to the reset-time threshold then.
    assign w_thresh = (afull_thresh == c_PTR_ZERO) ? c_AFULL_RESET : afull_thresh;

    always_comb begin
        w_wfull_next  = (w_wgray_next == w_rptr_full_cmp);
        // Modular subtraction; a stale read pointer can only over-report.
        w_wlevel_next = w_wbin_next - w_rbin;
        w_wafull_next = (w_wlevel_next >= w_thresh);
        // Set wins over clear when both happen in the same cycle.
        if (w_overflow) begin
            w_wovf_next = 1'b1;
        end else if (clr_ovf) begin
            w_wovf_next = 1'b0;
        end else begin
            w_wovf_next = r_wovf;
        end
    end

    // ------------------------------------------------------------------
    // Registers: pointer and every flag update on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_wbin   <= '0;
            r_waddr  <= '0;
            r_wptr   <= '0;
            r_wfull  <= 1'b0;
            r_wafull <= 1'b0;
            r_wlevel <= '0;
            r_wovf   <= 1'b0;
        end else begin
            r_wbin   <= w_wbin_next;
            r_waddr  <= w_wbin_next[ADDR_WIDTH-1:0];
            r_wptr   <= w_wgray_next;
            r_wfull  <= w_wfull_next;
            r_wafull <= w_wafull_next;
            r_wlevel <= w_wlevel_next;
            r_wovf   <= w_wovf_next;
        end
    end

    assign waddr  = r_waddr;
    assign wptr   = r_wptr;
    assign wfull  = r_wfull;
    assign wafull = r_wafull;
    assign wlevel = r_wlevel;
    assign wovf   = r_wovf;

endmodule : wptr_full_ctrl
`default_nettype wire

// File: tb/tb_wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wptr_full_ctrl
//  Description : Self-checking bench for wptr_full_ctrl (ADDR_WIDTH=3).
//                Directed vector table, a wrap sequence with a lagging read
//                pointer, and randomized traffic against an occupancy model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wptr_full_ctrl;

    localparam int c_AW    = 3;
    localparam int c_DEPTH = 8;
    localparam int c_MOD   = 16;

    logic       wclk = 1'b0;
    logic       wrst = 1'b0;
    logic       winc = 1'b0;
    logic [3:0] sync_rptr = '0;
    logic [3:0] afull_thresh = 4'd6;
    logic       clr_ovf = 1'b0;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       wfull;
    logic       wafull;
    logic [3:0] wlevel;
    logic       wovf;

    int n_pass  = 0;
    int n_total = 0;

    wptr_full_ctrl #(
        .ADDR_WIDTH (c_AW)
    ) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .winc         (winc),
        .sync_rptr    (sync_rptr),
        .afull_thresh (afull_thresh),
        .clr_ovf      (clr_ovf),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .wafull       (wafull),
        .wlevel       (wlevel),
        .wovf         (wovf)
    );

    always #5 wclk = ~wclk;

    function automatic logic [3:0] gray4(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    // Output bundle: {waddr, wptr, wfull, wafull, wlevel, wovf} = 14 bits.
    function automatic logic [13:0] pack(input logic [2:0] a, input logic [3:0] p,
                                         input logic f, input logic af,
                                         input logic [3:0] l, input logic o);
        return {a, p, f, af, l, o};
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got addr=%0d ptr=%b full=%b afull=%b lvl=%0d ovf=%b, want addr=%0d ptr=%b full=%b afull=%b lvl=%0d ovf=%b",
                     name, act[13:11], act[10:7], act[6], act[5], act[4:1], act[0],
                     exp[13:11], exp[10:7], exp[6], exp[5], exp[4:1], exp[0]);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b", name, act, exp);
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    function automatic logic [13:0] dut_out();
        return pack(waddr, wptr, wfull, wafull, wlevel, wovf);
    endfunction

    typedef struct {
        logic       rst;
        logic       inc;
        logic       clr;
        logic [3:0] rptr;
        logic [2:0] e_addr;
        logic [3:0] e_ptr;
        logic       e_full;
        logic       e_afull;
        logic [3:0] e_lvl;
        logic       e_ovf;
    } vec_t;

    localparam int c_NVEC = 17;
    vec_t vecs [c_NVEC];

    // Random-phase model state
    int m_wr, m_rd, m_lvl, m_thr;
    bit m_full, m_afull, m_ovf;

    initial begin
        // rst inc clr rptr     addr ptr      full afull lvl ovf   (thresh = 6)
        vecs[0]  = '{1, 1, 0, 4'b0000, 3'd0, 4'b0000, 0, 0, 4'd0, 0}; // reset wins over winc
        vecs[1]  = '{0, 1, 0, 4'b0000, 3'd1, 4'b0001, 0, 0, 4'd1, 0};
        vecs[2]  = '{0, 1, 0, 4'b0000, 3'd2, 4'b0011, 0, 0, 4'd2, 0};
        vecs[3]  = '{0, 1, 0, 4'b0000, 3'd3, 4'b0010, 0, 0, 4'd3, 0};
        vecs[4]  = '{0, 1, 0, 4'b0000, 3'd4, 4'b0110, 0, 0, 4'd4, 0};
        vecs[5]  = '{0, 1, 0, 4'b0000, 3'd5, 4'b0111, 0, 0, 4'd5, 0};
        vecs[6]  = '{0, 1, 0, 4'b0000, 3'd6, 4'b0101, 0, 1, 4'd6, 0}; // almost-full at 6
        vecs[7]  = '{0, 1, 0, 4'b0000, 3'd7, 4'b0100, 0, 1, 4'd7, 0};
        vecs[8]  = '{0, 1, 0, 4'b0000, 3'd0, 4'b1100, 1, 1, 4'd8, 0}; // full
        vecs[9]  = '{0, 1, 0, 4'b0000, 3'd0, 4'b1100, 1, 1, 4'd8, 1}; // overflow, hold
        vecs[10] = '{0, 0, 0, 4'b0001, 3'd0, 4'b1100, 0, 1, 4'd7, 1}; // drain one
        vecs[11] = '{0, 0, 1, 4'b0001, 3'd0, 4'b1100, 0, 1, 4'd7, 0}; // clear ovf
        vecs[12] = '{0, 1, 0, 4'b0001, 3'd1, 4'b1101, 1, 1, 4'd8, 0}; // full again
        vecs[13] = '{0, 1, 1, 4'b0001, 3'd1, 4'b1101, 1, 1, 4'd8, 1}; // set beats clear
        vecs[14] = '{0, 1, 0, 4'b0011, 3'd1, 4'b1101, 0, 1, 4'd7, 1}; // freed slot same cycle: refused
        vecs[15] = '{1, 1, 1, 4'b0000, 3'd0, 4'b0000, 0, 0, 4'd0, 0}; // reset mid-full
        vecs[16] = '{0, 1, 0, 4'b0000, 3'd1, 4'b0001, 0, 0, 4'd1, 0}; // first write right after reset

        #2;
        afull_thresh = 4'd6;
        for (int i = 0; i < c_NVEC; i++) begin
            wrst      = vecs[i].rst;
            winc      = vecs[i].inc;
            clr_ovf   = vecs[i].clr;
            sync_rptr = vecs[i].rptr;
            step();
            check($sformatf("vec%0d", i), dut_out(),
                  pack(vecs[i].e_addr, vecs[i].e_ptr, vecs[i].e_full,
                       vecs[i].e_afull, vecs[i].e_lvl, vecs[i].e_ovf));
        end

        // Wrap: 16 writes, read pointer follows the write pointer two cycles late.
        wrst = 1'b1; winc = 1'b0; clr_ovf = 1'b0; sync_rptr = '0;
        step();
        wrst = 1'b0;
        afull_thresh = 4'd8;
        for (int i = 0; i < 16; i++) begin
            winc      = 1'b1;
            sync_rptr = (i >= 2) ? gray4(i - 2) : 4'b0000;
            step();
            check_bit($sformatf("wrap_full%0d", i), wfull, 1'b0);
        end
        winc = 1'b0;
        check("wrap_end", pack(waddr, wptr, wfull, 1'b0, 4'd0, wovf),
              pack(3'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0));

        // Randomized traffic against an occupancy model.
        wrst = 1'b1; winc = 1'b0; clr_ovf = 1'b0; sync_rptr = '0;
        step();
        wrst = 1'b0;
        m_wr = 0; m_rd = 0; m_lvl = 0; m_full = 0; m_afull = 0; m_ovf = 0;
        m_thr = 6;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit r, inc, clr, acc;
            r   = ($urandom_range(0, 199) == 0);
            inc = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) m_thr = $urandom_range(1, c_DEPTH);
            if (r) begin
                m_rd = 0;
            end else if (((m_wr - m_rd + c_MOD) % c_MOD) > 0 && $urandom_range(0, 99) < 40) begin
                m_rd = (m_rd + 1) % c_MOD;
            end
            wrst = r; winc = inc; clr_ovf = clr;
            sync_rptr = gray4(m_rd);
            afull_thresh = 4'(m_thr);
            if (r) begin
                m_wr = 0; m_lvl = 0; m_full = 0; m_afull = 0; m_ovf = 0;
            end else begin
                acc = inc && !m_full;
                if (inc && m_full) m_ovf = 1;
                else if (clr)      m_ovf = 0;
                if (acc) m_wr = (m_wr + 1) % c_MOD;
                m_lvl   = (m_wr - m_rd + c_MOD) % c_MOD;
                m_full  = (m_lvl == c_DEPTH);
                m_afull = (m_lvl >= m_thr);
            end
            step();
            check($sformatf("rand%0d", cyc), dut_out(),
                  pack(3'(m_wr % c_DEPTH), gray4(m_wr), m_full, m_afull, 4'(m_lvl), m_ovf));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_wptr_full_ctrl
`default_nettype wire

// File: doc/wptr_full_ctrl.md
WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, FIFO address bits; legal range 2..12; DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter AFULL_RESET, default DEPTH-2, afull_thresh value used at reset before software programs the register.
REQ-003 SHALL have port wclk  input  1  write-domain clock; the block has one clock and all logic is rising-edge wclk.
REQ-004 SHALL have port wrst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port winc  input  1  write request for the current cycle.
REQ-006 SHALL have port sync_rptr  input  ADDR_WIDTH+1  read pointer in Gray code, already synchronised into wclk.
REQ-007 SHALL have port afull_thresh  input  ADDR_WIDTH+1  almost-full level, range 1..DEPTH.
REQ-008 SHALL have port clr_ovf  input  1  clears the sticky overflow flag.
REQ-009 SHALL have port waddr  output  ADDR_WIDTH  RAM write address.
REQ-010 SHALL have port wptr  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
REQ-011 SHALL have port wfull  output  1  registered full flag.
REQ-012 SHALL have port wafull  output  1  registered almost-full flag.
REQ-013 SHALL have port wlevel  output  ADDR_WIDTH+1  registered occupancy as seen from the write side, range 0..DEPTH.
REQ-014 SHALL have port wovf  output  1  sticky overflow error flag.

Function
REQ-015 A write SHALL be accepted in a cycle only when winc=1 and wfull=0; acceptance SHALL be the only event that advances the pointer.
REQ-016 On acceptance, binary pointer wbin (ADDR_WIDTH+1 bits) SHALL increment by 1 modulo 2**(ADDR_WIDTH+1), with natural wrap.
REQ-017 waddr SHALL equal wbin[ADDR_WIDTH-1:0] and SHALL be registered, not decoded.
REQ-018 wptr SHALL equal the Gray code of wbin and SHALL be registered from the next-state binary value, so wptr never glitches.
REQ-019 Next-state wfull SHALL be 1 when the next Gray pointer equals sync_rptr with its two MSBs inverted and all other bits equal.
REQ-020 rbin SHALL be the Gray-to-binary conversion of sync_rptr; next-state wlevel SHALL be (wbin_next - rbin) modulo 2**(ADDR_WIDTH+1).
REQ-021 Next-state wafull SHALL be 1 when wlevel_next >= afull_thresh.
REQ-022 wfull, wafull and wlevel SHALL all update on the same edge as wptr (zero-cycle latency relative to the pointer, one cycle from winc).
REQ-023 A stale sync_rptr SHALL only make flags pessimistic: wfull and wafull may stay set late but SHALL never clear early.
REQ-024 winc=1 while wfull=1 SHALL set wovf on the next edge and SHALL leave pointers, waddr and wlevel unchanged.
REQ-025 wovf SHALL stay set until clr_ovf=1; if a new overflow and clr_ovf occur in the same cycle, set SHALL win.
REQ-026 A freed slot seen via sync_rptr in the same cycle as winc SHALL not allow that write; the write is decided on the registered wfull only.

Reset
REQ-027 When wrst=1 at a rising wclk edge, waddr, wptr, wlevel and wbin SHALL become 0, and wfull, wafull and wovf SHALL become 0.
REQ-028 Reset SHALL take priority over winc and clr_ovf, including mid-burst and while the FIFO is full.
REQ-029 The first accepted write after reset deassertion SHALL be possible in the cycle immediately following.

Structure
REQ-030 A shared package SHALL hold the default ADDR_WIDTH, the DEPTH derivation and the Gray/binary width constants.
REQ-031 The block SHALL instantiate the existing bin_to_gray_converter for wptr and one new sub-module, gray_to_bin_converter, for sync_rptr.
REQ-032 The implementation SHALL be a single registered pointer/flag datapath with no FSM beyond the sticky overflow bit.

Verification (ADDR_WIDTH=3, DEPTH=8)
REQ-033 Reset: wrst=1 for one edge with winc=1 -> waddr=0, wptr=4'b0000, wfull=0, wafull=0, wlevel=0, wovf=0.
REQ-034 Fill: sync_rptr=0, winc=1 for 8 cycles -> wptr follows 0001,0011,0010,0110,0111,0101,0100,1100; wfull=1 and wlevel=8 after the 8th edge; a 9th winc -> wptr holds 1100 and wovf=1.
REQ-035 Almost-full: afull_thresh=6 -> wafull rises on the edge of the 6th write (wlevel=6), wfull=0.
REQ-036 Drain: from full, sync_rptr=4'b0001 -> next edge wfull=0 and wlevel=7; clr_ovf=1 -> wovf=0.
REQ-037 Wrap: 16 accepted writes with sync_rptr tracking wptr two cycles late -> wptr returns to 0000, waddr=0, and wfull is never set.
REQ-038 Overflow/clear collision and reset mid-full: winc=1 and clr_ovf=1 while full -> wovf stays 1; then wrst=1 -> all outputs 0 on that edge.
